decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the core, directly downstream of the fetch stage. Registers the fetched instruction word and PC, squashes bubbles, discarded words and post-redirect wrong-path words, and decodes RV32I fields, the immediate and control flags. The registered outputs feed register-file read and the execute stage one cycle later. Decode is combinational on the input word; all outputs come from one pipeline register.

## Interface
Parameters:
- `RESET_PC`, `32'h40000000`: PC reported while the stage holds a bubble after reset.
- `NOP`, `32'h00000033`: bubble encoding (`add x0,x0,x0`) used by fetch and by this stage.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold the pipeline register (downstream busy).
- `flush` in 1: redirect from execute; squash the register contents.
- `kill_cnt` in 2: number of wrong-path fetch words still in flight, sampled with `flush`.
- `pc_in` in 32: PC of `instr_in` from fetch.
- `instr_in` in 32: fetched word, byte-swapped to little-endian order; `NOP` means no instruction.
- `discard_in` in 1: fetch marks the word as discarded.
- `misaligned_in` in 1: instruction-address-misaligned flag from fetch.
- `valid_d` out 1: register holds a real instruction.
- `pc_d` out 32, `instr_d` out 32: registered PC and word.
- `rd_d`, `rs1_d`, `rs2_d` out 5 each: register indices; 0 when the format does not use them.
- `funct3_d` out 3, `opcode_d` out 7: raw fields.
- `imm_d` out 32: sign-extended immediate per format.
- `ctrl_d` out 8: {`is_system`, `is_jalr`, `is_jal`, `is_branch`, `is_store`, `is_load`, `writes_rd`, `alu_imm`}.
- `illegal_d` out 1: instruction is not legal RV32I.
- `misaligned_d` out 1: registered copy of `misaligned_in`.

## Operation
- Priority of updates, highest first: `rst`, `flush`, `stall`, capture.
- Reset: `valid_d=0`, `pc_d=RESET_PC`, `instr_d=NOP`. All other outputs are 0. `kill_rem` is 0.
- `flush=1`: the register is loaded with a bubble, and `kill_rem <= kill_cnt`. This overrides `stall`.
- `stall=1` (no flush): all outputs and `kill_rem` hold.
- Capture: the word is accepted as real when `instr_in != NOP`, `!discard_in` and `kill_rem == 0`.
  - A real word loads the register with decoded fields and sets `valid_d=1`.
  - Otherwise the stage loads a bubble: `valid_d=0`, `instr_d=NOP`, `pc_d=pc_in`, all fields, `ctrl_d`, `illegal_d` and `misaligned_d` 0.
- `kill_rem` decrements by 1 on each non-stalled capture cycle in which a non-`NOP`, non-discarded word arrives while `kill_rem > 0`. It saturates at 0.
- Immediate formats, sign bit `instr[31]`:
  - I: loads, OP-IMM, JALR, SYSTEM.
  - S: stores.
  - B: branches, bit 0 = 0.
  - U: LUI/AUIPC, low 12 bits 0.
  - J: JAL, bit 0 = 0.
  - R-type: immediate is 0.
- `illegal_d=1` (with `valid_d=1`) in any of these cases:
  - `instr[1:0] != 2'b11`.
  - Opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
  - BRANCH with funct3 in {010, 011}.
  - LOAD with funct3 in {011, 110, 111}.
  - STORE with funct3 > 010.
  - JALR with funct3 != 0.
  - OP with funct7 not in {0000000, 0100000}, or with 0100000 on funct3 other than 000/101.
  - OP-IMM shifts with an invalid funct7.
- For an illegal word, `ctrl_d` is 0; `pc_d` and `instr_d` are still registered so execute can raise the trap.
- `misaligned_in=1` is forwarded with a real word even when the word decodes legal. Execute gives it precedence over `illegal_d`.
- `writes_rd` is forced to 0 when `rd == 0`.

## Timing
- Latency is 1 cycle: a word presented in cycle N appears on the outputs after edge N+1.
- No combinational path from any input to any output.
- Simultaneous `flush` and `stall`: flush wins, the register becomes a bubble, and `kill_rem` loads.
- Simultaneous `flush` and a real incoming word: the word is dropped and is not counted against `kill_cnt`.
- `rst` mid-stall or mid-kill: outputs return to reset values and `kill_rem` clears on the next edge.
- `kill_cnt=0` with `flush`: only the register is squashed; the next real word is accepted.

## Test plan
- Reset then release, with `instr_in=NOP` → `valid_d=0`, `instr_d=32'h00000033`, `pc_d=32'h40000000` held.
- `instr_in=32'hFFC10093` (`addi x1,x2,-4`), `pc_in=32'h40000010` → next cycle `valid_d=1`, `rd_d=1`, `rs1_d=2`, `imm_d=32'hFFFFFFFC`, `alu_imm=1`, `writes_rd=1`.
- `instr_in=32'hFE0008E3` (`beq x0,x0,-16`) → `is_branch=1`, `imm_d=32'hFFFFFFF0`, `writes_rd=0`. Then `instr_in=32'h0000A003` (LOAD funct3=010 into x0) → `is_load=1`, `writes_rd=0`.
- `flush=1`, `kill_cnt=2`, then three real words A, B, C on consecutive cycles → A and B squashed (`valid_d=0`), C registered with `valid_d=1`. Repeat with `stall=1` between A and B → squash count unaffected by stalled cycles.
- `stall=1` for 3 cycles with a changing `instr_in` → outputs constant. `flush` and `stall` asserted together → `valid_d=0` next cycle.
- `instr_in=32'h00003003` (LOAD funct3=011) → `illegal_d=1`, `valid_d=1`, `ctrl_d=0`. `discard_in=1` with a legal word → bubble. `misaligned_in=1` with a legal word → `misaligned_d=1`.

Source files
------------

// File: rtl/decode_stage.sv
// Decode pipeline stage: registers the fetched word and PC, squashes bubbles and
// wrong-path words after a redirect, and decodes RV32I fields, immediate and control flags.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h40000000,
  parameter logic [31:0] NOP      = 32'h00000033
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  kill_cnt,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        discard_in,
  input  logic        misaligned_in,
  output logic        valid_d,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic [4:0]  rd_d,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [2:0]  funct3_d,
  output logic [6:0]  opcode_d,
  output logic [31:0] imm_d,
  output logic [7:0]  ctrl_d,
  output logic        illegal_d,
  output logic        misaligned_d
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;
  logic        d_illegal;
  logic        f_sys, f_jalr, f_jal, f_br, f_st, f_ld, f_wr, f_alui;
  logic [7:0]  d_ctrl;
  logic [1:0]  kill_rem;
  logic        real_word;
  logic        accept;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  always_comb begin
    d_rd = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_imm = 32'd0; d_illegal = 1'b0;
    f_sys = 1'b0; f_jalr = 1'b0; f_jal = 1'b0; f_br = 1'b0;
    f_st = 1'b0; f_ld = 1'b0; f_wr = 1'b0; f_alui = 1'b0;
    // Every legal opcode ends in 2'b11, so a compressed/invalid low pair falls to default.
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        d_rd = instr_in[11:7]; d_imm = {instr_in[31:12], 12'd0}; f_wr = 1'b1;
      end
      OP_JAL: begin
        d_rd = instr_in[11:7]; f_jal = 1'b1; f_wr = 1'b1;
        d_imm = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      end
      OP_JALR: begin
        d_rd = instr_in[11:7]; d_rs1 = instr_in[19:15]; f_jalr = 1'b1; f_wr = 1'b1;
        d_imm = {{20{instr_in[31]}}, instr_in[31:20]};
        d_illegal = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        d_rs1 = instr_in[19:15]; d_rs2 = instr_in[24:20]; f_br = 1'b1;
        d_imm = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
        d_illegal = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        d_rd = instr_in[11:7]; d_rs1 = instr_in[19:15]; f_ld = 1'b1; f_wr = 1'b1;
        d_imm = {{20{instr_in[31]}}, instr_in[31:20]};
        d_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        d_rs1 = instr_in[19:15]; d_rs2 = instr_in[24:20]; f_st = 1'b1;
        d_imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
        d_illegal = (funct3 > 3'b010);
      end
      OP_IMM: begin
        d_rd = instr_in[11:7]; d_rs1 = instr_in[19:15]; f_alui = 1'b1; f_wr = 1'b1;
        d_imm = {{20{instr_in[31]}}, instr_in[31:20]};
        d_illegal = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                    ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
      end
      OP_OP: begin
        d_rd = instr_in[11:7]; d_rs1 = instr_in[19:15]; d_rs2 = instr_in[24:20]; f_wr = 1'b1;
        d_illegal = !((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_MISC: begin
        d_illegal = 1'b0;
      end
      OP_SYSTEM: begin
        d_rd = instr_in[11:7]; d_rs1 = instr_in[19:15]; f_sys = 1'b1; f_wr = 1'b1;
        d_imm = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      default: d_illegal = 1'b1;
    endcase
    d_ctrl = d_illegal ? 8'd0
                       : {f_sys, f_jalr, f_jal, f_br, f_st, f_ld, f_wr && (d_rd != 5'd0), f_alui};
  end

  assign real_word = (instr_in != NOP) && !discard_in;
  assign accept    = real_word && (kill_rem == 2'd0);

  // Flow control: stall freezes the register and kill_rem; flush overrides stall and
  // loads a bubble plus the wrong-path count; otherwise a new word is captured every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d <= 1'b0; pc_d <= RESET_PC; instr_d <= NOP;
      rd_d <= 5'd0; rs1_d <= 5'd0; rs2_d <= 5'd0; funct3_d <= 3'd0; opcode_d <= 7'd0;
      imm_d <= 32'd0; ctrl_d <= 8'd0; illegal_d <= 1'b0; misaligned_d <= 1'b0;
      kill_rem <= 2'd0;
    end else if (flush) begin
      valid_d <= 1'b0; pc_d <= pc_in; instr_d <= NOP;
      rd_d <= 5'd0; rs1_d <= 5'd0; rs2_d <= 5'd0; funct3_d <= 3'd0; opcode_d <= 7'd0;
      imm_d <= 32'd0; ctrl_d <= 8'd0; illegal_d <= 1'b0; misaligned_d <= 1'b0;
      kill_rem <= kill_cnt;
    end else if (!stall) begin
      pc_d <= pc_in;
      if (accept) begin
        valid_d <= 1'b1; instr_d <= instr_in;
        rd_d <= d_rd; rs1_d <= d_rs1; rs2_d <= d_rs2; funct3_d <= funct3; opcode_d <= opcode;
        imm_d <= d_imm; ctrl_d <= d_ctrl; illegal_d <= d_illegal; misaligned_d <= misaligned_in;
      end else begin
        valid_d <= 1'b0; instr_d <= NOP;
        rd_d <= 5'd0; rs1_d <= 5'd0; rs2_d <= 5'd0; funct3_d <= 3'd0; opcode_d <= 7'd0;
        imm_d <= 32'd0; ctrl_d <= 8'd0; illegal_d <= 1'b0; misaligned_d <= 1'b0;
      end
      if (real_word && (kill_rem != 2'd0)) kill_rem <= kill_rem - 2'd1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: hand-computed vector table, hand sequences for the
// flush/stall/kill corner cases, and random traffic against a behavioural model.
module tb_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h40000000;
  localparam logic [31:0] NOP      = 32'h00000033;

  logic        clk = 1'b0;
  logic        rst, stall, flush, discard_in, misaligned_in;
  logic [1:0]  kill_cnt;
  logic [31:0] pc_in, instr_in;
  logic        valid_d, illegal_d, misaligned_d;
  logic [31:0] pc_d, instr_d, imm_d;
  logic [4:0]  rd_d, rs1_d, rs2_d;
  logic [2:0]  funct3_d;
  logic [6:0]  opcode_d;
  logic [7:0]  ctrl_d;

  decode_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .kill_cnt(kill_cnt),
    .pc_in(pc_in), .instr_in(instr_in), .discard_in(discard_in), .misaligned_in(misaligned_in),
    .valid_d(valid_d), .pc_d(pc_d), .instr_d(instr_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .funct3_d(funct3_d), .opcode_d(opcode_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
    .illegal_d(illegal_d), .misaligned_d(misaligned_d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        illegal;
    logic        misaligned;
  } out_t;

  typedef struct {
    logic [31:0] instr, pc;
    logic        disc, mis;
    logic        valid;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        ill;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  out_t m_out;
  int   m_kill;

  function automatic longint sext(input longint v, input int bits);
    return v - ((v >> (bits - 1)) & 1) * (longint'(1) << bits);
  endfunction

  // Reference: classify the word by mnemonic group, then derive fields from that class.
  function automatic out_t model_decode(input logic [31:0] w, input logic [31:0] pc, input logic mis);
    out_t  o;
    string fmt;
    bit    legal;
    int    f3, f7;
    longint v;
    o = '0;
    o.valid = 1'b1; o.pc = pc; o.instr = w; o.misaligned = mis;
    o.funct3 = w[14:12]; o.opcode = w[6:0];
    f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    legal = 1'b1;
    case (w[6:0])
      7'h37, 7'h17: fmt = "U";
      7'h6F:        fmt = "J";
      7'h67: begin fmt = "I"; legal = (f3 == 0); end
      7'h63: begin fmt = "B"; legal = !(f3 inside {2, 3}); end
      7'h03: begin fmt = "I"; legal = f3 inside {0, 1, 2, 4, 5}; end
      7'h23: begin fmt = "S"; legal = f3 inside {0, 1, 2}; end
      7'h13: begin
        fmt = "I";
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = (f7 == 0) || (f7 == 32);
      end
      7'h33: begin fmt = "R"; legal = (f7 == 0) || ((f7 == 32) && (f3 == 0 || f3 == 5)); end
      7'h0F: fmt = "N";
      7'h73: fmt = "I";
      default: begin fmt = "X"; legal = 1'b0; end
    endcase
    if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") o.rd = w[11:7];
    if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") o.rs1 = w[19:15];
    if (fmt == "R" || fmt == "S" || fmt == "B") o.rs2 = w[24:20];
    v = 0;
    if (fmt == "I") v = sext(longint'(w[31:20]), 12);
    if (fmt == "S") v = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
    if (fmt == "B") v = sext(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                             longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
    if (fmt == "U") v = longint'(w & 32'hFFFFF000);
    if (fmt == "J") v = sext(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                             longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
    o.imm = v[31:0];
    o.illegal = !legal;
    if (legal) begin
      o.ctrl[7] = (w[6:0] == 7'h73);
      o.ctrl[6] = (w[6:0] == 7'h67);
      o.ctrl[5] = (w[6:0] == 7'h6F);
      o.ctrl[4] = (w[6:0] == 7'h63);
      o.ctrl[3] = (w[6:0] == 7'h23);
      o.ctrl[2] = (w[6:0] == 7'h03);
      o.ctrl[1] = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") && (w[11:7] != 0);
      o.ctrl[0] = (w[6:0] == 7'h13);
    end
    return o;
  endfunction

  function automatic out_t bubble(input logic [31:0] pc);
    out_t o;
    o = '0;
    o.pc = pc; o.instr = NOP;
    return o;
  endfunction

  function automatic out_t dut_out();
    return {valid_d, pc_d, instr_d, rd_d, rs1_d, rs2_d, funct3_d, opcode_d,
            imm_d, ctrl_d, illegal_d, misaligned_d};
  endfunction

  // Drive one cycle, advance the model, compare the whole output bundle after the edge.
  task automatic step(input logic r, input logic f, input logic s, input logic [1:0] kc,
                      input logic [31:0] pc, input logic [31:0] w, input logic disc,
                      input logic mis, input string name, input int exp_valid);
    bit is_real;
    out_t got;
    rst = r; flush = f; stall = s; kill_cnt = kc; pc_in = pc; instr_in = w;
    discard_in = disc; misaligned_in = mis;
    is_real = (w != NOP) && !disc;
    if (r) begin
      m_out = bubble(RESET_PC); m_kill = 0;
    end else if (f) begin
      m_out = bubble(pc); m_kill = int'(kc);
    end else if (!s) begin
      if (is_real && m_kill == 0) m_out = model_decode(w, pc, mis);
      else m_out = bubble(pc);
      if (is_real && m_kill > 0) m_kill = m_kill - 1;
    end
    @(posedge clk);
    #1;
    got = dut_out();
    n_cmp++;
    if (got !== m_out) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, m_out);
    end
    if (exp_valid >= 0) begin
      n_cmp++;
      if (valid_d !== exp_valid[0]) begin
        n_err++;
        $display("FAIL %s valid_d: got %0b want %0d", name, valid_d, exp_valid);
      end
    end
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] a, b, c, x, w;
    logic [6:0]  ops[12];
    logic [6:0]  f7s[3];
    logic [57:0] got_t, exp_t;

    vecs[0]  = '{32'hFFC10093, 32'h40000010, 0, 0, 1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 8'h03, 0};
    vecs[1]  = '{32'hFE0008E3, 32'h40000014, 0, 0, 1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF0, 8'h10, 0};
    vecs[2]  = '{32'h0000A003, 32'h40000018, 0, 0, 1, 5'd0, 5'd1, 5'd0, 32'h00000000, 8'h04, 0};
    vecs[3]  = '{32'h00003003, 32'h4000001C, 0, 0, 1, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 1};
    vecs[4]  = '{32'hFFC10093, 32'h40000020, 1, 0, 0, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 0};
    vecs[5]  = '{32'hFFC10093, 32'h40000022, 0, 1, 1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 8'h03, 0};
    vecs[6]  = '{32'h002081B3, 32'h40000024, 0, 0, 1, 5'd3, 5'd1, 5'd2, 32'h00000000, 8'h02, 0};
    vecs[7]  = '{32'h407312B3, 32'h40000028, 0, 0, 1, 5'd5, 5'd6, 5'd7, 32'h00000000, 8'h00, 1};
    vecs[8]  = '{32'h12345537, 32'h4000002C, 0, 0, 1, 5'd10, 5'd0, 5'd0, 32'h12345000, 8'h02, 0};
    vecs[9]  = '{32'h008000EF, 32'h40000030, 0, 0, 1, 5'd1, 5'd0, 5'd0, 32'h00000008, 8'h22, 0};
    vecs[10] = '{32'hFE20AE23, 32'h40000034, 0, 0, 1, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 8'h08, 0};
    vecs[11] = '{32'h00009067, 32'h40000038, 0, 0, 1, 5'd0, 5'd1, 5'd0, 32'h00000000, 8'h00, 1};
    vecs[12] = '{32'h00000073, 32'h4000003C, 0, 0, 1, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h80, 0};
    vecs[13] = '{32'h00000012, 32'h40000040, 0, 0, 1, 5'd0, 5'd0, 5'd0, 32'h00000000, 8'h00, 1};

    rst = 1'b1; flush = 1'b0; stall = 1'b0; kill_cnt = 2'd0; pc_in = RESET_PC;
    instr_in = NOP; discard_in = 1'b0; misaligned_in = 1'b0;
    m_out = bubble(RESET_PC); m_kill = 0;

    // Clock/reset block
    step(1, 0, 0, 0, 32'h12345678, 32'hFFC10093, 0, 0, "reset", 0);
    step(1, 0, 0, 0, RESET_PC, NOP, 0, 0, "reset2", 0);
    n_cmp++;
    if (pc_d !== RESET_PC || instr_d !== NOP) begin
      n_err++;
      $display("FAIL reset_pc_instr: got %h/%h want %h/%h", pc_d, instr_d, RESET_PC, NOP);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, RESET_PC, NOP, 0, 0, "idle_nop", 0);

    // Vector table, compared against the hand-computed expectations as well as the model
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 0, 0, vecs[i].pc, vecs[i].instr, vecs[i].disc, vecs[i].mis, $sformatf("vec%0d", i), -1);
      exp_t = {vecs[i].valid, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].ctrl,
               vecs[i].ill, vecs[i].mis & vecs[i].valid};
      got_t = {valid_d, rd_d, rs1_d, rs2_d, imm_d, ctrl_d, illegal_d, misaligned_d};
      n_cmp++;
      if (got_t !== exp_t) begin
        n_err++;
        $display("FAIL vec%0d_fields: got %h want %h", i, got_t, exp_t);
      end
    end

    a = 32'h00108093; b = 32'h00210113; c = 32'h00318193; x = 32'h002081B3;
    // Flush with kill_cnt=2 (incoming word dropped, not counted), then A,B squashed, C kept
    step(0, 1, 0, 2, 32'h40000100, x, 0, 0, "flush_k2", 0);
    step(0, 0, 0, 0, 32'h40000104, a, 0, 0, "kill_a", 0);
    step(0, 0, 0, 0, 32'h40000108, b, 0, 0, "kill_b", 0);
    step(0, 0, 0, 0, 32'h4000010C, c, 0, 0, "keep_c", 1);
    n_cmp++;
    if (instr_d !== c) begin
      n_err++;
      $display("FAIL keep_c_instr: got %h want %h", instr_d, c);
    end
    // Same with stalled cycles between A and B
    step(0, 1, 0, 2, 32'h40000200, x, 0, 0, "flush_k2s", 0);
    step(0, 0, 0, 0, 32'h40000204, a, 0, 0, "kill_a_s", 0);
    step(0, 0, 1, 0, 32'h40000208, b, 0, 0, "stall_b1", 0);
    step(0, 0, 1, 0, 32'h40000208, b, 0, 0, "stall_b2", 0);
    step(0, 0, 0, 0, 32'h40000208, b, 0, 0, "kill_b_s", 0);
    step(0, 0, 0, 0, 32'h4000020C, c, 0, 0, "keep_c_s", 1);
    // NOPs and discarded words do not consume the kill count
    step(0, 1, 0, 1, 32'h40000300, NOP, 0, 0, "flush_k1", 0);
    step(0, 0, 0, 0, 32'h40000304, NOP, 0, 0, "kill_nop", 0);
    step(0, 0, 0, 0, 32'h40000308, a, 1, 0, "kill_disc", 0);
    step(0, 0, 0, 0, 32'h4000030C, a, 0, 0, "kill_a1", 0);
    step(0, 0, 0, 0, 32'h40000310, b, 0, 0, "keep_b1", 1);
    // Stall holds outputs while instr_in changes
    step(0, 0, 0, 0, 32'h40000400, x, 0, 1, "pre_stall", 1);
    step(0, 0, 1, 0, 32'h40000404, a, 0, 0, "stall1", 1);
    step(0, 0, 1, 0, 32'h40000408, b, 0, 0, "stall2", 1);
    step(0, 0, 1, 0, 32'h4000040C, c, 1, 0, "stall3", 1);
    n_cmp++;
    if (instr_d !== x || pc_d !== 32'h40000400) begin
      n_err++;
      $display("FAIL stall_hold: got %h/%h want %h/%h", instr_d, pc_d, x, 32'h40000400);
    end
    // Flush and stall together; kill_cnt=0 means the next word is accepted
    step(0, 1, 1, 0, 32'h40000500, a, 0, 0, "flush_stall", 0);
    step(0, 0, 0, 0, 32'h40000504, b, 0, 0, "after_k0", 1);
    // Reset in the middle of a kill window clears the count
    step(0, 1, 0, 3, 32'h40000600, a, 0, 0, "flush_k3", 0);
    step(0, 0, 0, 0, 32'h40000604, a, 0, 0, "kill_r", 0);
    step(1, 0, 1, 0, 32'h40000608, b, 0, 0, "rst_mid", 0);
    step(0, 0, 0, 0, 32'h4000060C, c, 0, 0, "post_rst", 1);

    // Random traffic
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h5B};
    f7s = '{7'h00, 7'h20, 7'h01};
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) == 0) w = NOP;
      if ($urandom_range(0, 19) == 0) w[1:0] = 2'($urandom_range(0, 2));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
           2'($urandom_range(0, 3)), $urandom, w, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, "random", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
